// File: rtl/md_unit.sv
// Multiply/divide unit holding the architectural HI/LO pair; mult/div results commit after a fixed countdown.
// Latency: MULT_CYCLES (mult/multu/madd/maddu) or DIV_CYCLES (div/divu) busy cycles; mthi/mtlo write in one cycle.
// Backpressure: busy is high while an operation is in flight; start while busy is dropped, so the controller must stall.
// Optional feature: define MD_MADD_EN to enable madd/maddu (MDOp 110/111); otherwise those encodings are no-ops.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_res;
  logic        r_skip;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_long_op;
  logic        w_launch;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_is_div;

  logic signed [63:0] w_mul_s;
  logic        [63:0] w_mul_u;
  logic        [31:0] w_dvs;
  logic        [31:0] w_qs;
  logic        [31:0] w_rs;
  logic        [31:0] w_qu;
  logic        [31:0] w_ru;
  logic        [63:0] w_res;
  logic               w_skip;

`ifdef MD_MADD_EN
  logic        [63:0] w_acc;
`endif

  // Full-width products; sign extension to 64 bits gives the exact signed result.
  always_comb begin
    w_mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    w_mul_u = {32'd0, A} * {32'd0, B};
  end

  // Quotient/remainder; a zero divisor is replaced by 1 so the divider never sees 0 (result is discarded anyway).
  always_comb begin
    w_dvs = (B == 32'd0) ? 32'd1 : B;
    w_qs  = '0;
    w_rs  = '0;
    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      // Signed overflow case is pinned explicitly rather than left to the divider.
      w_qs = 32'h8000_0000;
      w_rs = 32'd0;
    end else begin
      w_qs = $signed(A) / $signed(w_dvs);
      w_rs = $signed(A) % $signed(w_dvs);
    end
    w_qu = A / w_dvs;
    w_ru = A % w_dvs;
  end

`ifdef MD_MADD_EN
  // Accumulate onto the HI/LO value present at the start edge, 64-bit wrap.
  always_comb begin
    w_acc = {r_hi, r_lo} + (MDOp[0] ? w_mul_u : $unsigned(w_mul_s));
  end
`endif

  // Select the result to park in the temps and whether the commit must leave HI/LO alone.
  always_comb begin
    w_res  = '0;
    w_skip = 1'b0;
    case (MDOp)
      OP_MULT:  w_res = $unsigned(w_mul_s);
      OP_MULTU: w_res = w_mul_u;
      OP_DIV: begin
        w_res  = {w_rs, w_qs};
        w_skip = (B == 32'd0);
      end
      OP_DIVU: begin
        w_res  = {w_ru, w_qu};
        w_skip = (B == 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: w_res = w_acc;
`endif
      default: begin
        w_res  = '0;
        w_skip = 1'b0;
      end
    endcase
  end

  // Which encodings start a multi-cycle operation.
  always_comb begin
    w_long_op = 1'b0;
    case (MDOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_long_op = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU:                  w_long_op = 1'b1;
`endif
      default:                            w_long_op = 1'b0;
    endcase
    w_is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and control strobes; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_long_op) begin
            w_launch    = 1'b1;
            w_state_nxt = S_RUN;
          end else if (MDOp == OP_MTHI) begin
            w_wr_hi = 1'b1;
          end else if (MDOp == OP_MTLO) begin
            w_wr_lo = 1'b1;
          end
        end
      end
      S_RUN: begin
        // The edge that takes the counter to zero commits and drops busy together.
        if (r_cnt <= 5'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Countdown and result temps; operands are consumed at the start edge so later A/B changes are irrelevant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_res  <= '0;
      r_skip <= 1'b0;
    end else if (w_launch) begin
      r_cnt  <= w_is_div ? DIV_N : MULT_N;
      r_res  <= w_res;
      r_skip <= w_skip;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  // Architectural HI/LO: written only at commit (unless divide by zero) or by mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_skip) begin
        r_hi <= r_res[63:32];
        r_lo <= r_res[31:0];
      end
    end else if (w_wr_hi) begin
      r_hi <= A;
    end else if (w_wr_lo) begin
      r_lo <= A;
    end
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO values and busy-length counts.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every comparison goes through chk; summary line is printed at the end.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk;
  int n_bad;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle start strobe; returns on the falling edge right after the start edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling-edge samples with busy high, bounded so a stuck busy cannot hang the run.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    start = 1'b0;
    MDOp  = 3'b000;
    A     = '0;
    B     = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;

    // mult -2 * 3 = -6
    do_op(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_busy(cnt);
    chk("mult_cycles", cnt, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    do_op(3'b001, 32'hFFFF_FFFF, 32'd2);
    wait_busy(cnt);
    chk("multu_cycles", cnt, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2 = -3 rem -1
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_busy(cnt);
    chk("div_cycles", cnt, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // mthi/mtlo single cycle
    do_op(3'b100, 32'h0000_0011, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h0000_0011);
    do_op(3'b101, 32'h0000_0022, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", LO, 32'h0000_0022);
    chk("mtlo_hi_kept", HI, 32'h0000_0011);

    // divu by zero: full busy length, HI/LO untouched
    do_op(3'b011, 32'd7, 32'd0);
    wait_busy(cnt);
    chk("divz_cycles", cnt, 32'd10);
    chk("divz_hi", HI, 32'h0000_0011);
    chk("divz_lo", LO, 32'h0000_0022);

    // signed overflow
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(cnt);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0000_0000);

    // divu 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
    do_op(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_busy(cnt);
    chk("divu_lo", LO, 32'h7FFF_FFFC);
    chk("divu_hi", HI, 32'h0000_0001);

    // starts while busy are dropped: div 100/7 = 14 rem 2
    do_op(3'b010, 32'd100, 32'd7);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 2) begin
        start = 1'b1; MDOp = 3'b000; A = 32'd5; B = 32'd5;
      end else if (cnt == 3) begin
        start = 1'b1; MDOp = 3'b101; A = 32'h55; B = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_cycles", cnt, 32'd10);
    chk("ign_lo", LO, 32'd14);
    chk("ign_hi", HI, 32'd2);
    repeat (3) @(negedge clk);
    chk("ign_no_late_busy", {31'd0, busy}, 32'd0);
    chk("ign_lo_late", LO, 32'd14);

    // async reset mid-mult
    do_op(3'b000, 32'd3, 32'd3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_commit", LO, 32'd0);
    do_op(3'b000, 32'd7, 32'd6);
    wait_busy(cnt);
    chk("post_rst_cycles", cnt, 32'd5);
    chk("post_rst_lo", LO, 32'd42);
    chk("post_rst_hi", HI, 32'd0);

    // madd 1*1 onto {0, 0xFFFFFFFF}
    do_op(3'b100, 32'd0, 32'd0);
    do_op(3'b101, 32'hFFFF_FFFF, 32'd0);
    do_op(3'b110, 32'd1, 32'd1);
    wait_busy(cnt);
`ifdef MD_MADD_EN
    chk("madd_cycles", cnt, 32'd5);
    chk("madd_hi", HI, 32'h0000_0001);
    chk("madd_lo", LO, 32'h0000_0000);
`else
    chk("madd_cycles", cnt, 32'd0);
    chk("madd_hi", HI, 32'h0000_0000);
    chk("madd_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
